// File: rtl/axis_s_bk_bridge.sv
// -----------------------------------------------------------------------------
// axis_s_bk_bridge
//   Terminates an AXI-Stream slave port and feeds the backend bk_* handshake.
//   Incoming beats are buffered in a small FIFO. Each buffered beat is issued
//   to the backend as one bk_start pulse. The payload is held stable until the
//   backend answers with bk_done, and it stays held after that.
//
// Ports
//   axi_aclk, axi_areset      clock, asynchronous active-high reset
//   axis_t*                   AXI-Stream slave side (tready is an output)
//   bk_start                  one-cycle pulse per backend transaction
//   bk_data/tstrb/tkeep/user/last  registered payload of the current beat
//   bk_nordy                  backend cannot accept a new transaction
//   bk_done                   backend finished the current transaction
//   fifo_level                current FIFO occupancy (0..FIFO_DEPTH)
//   done_cnt                  completed backend transactions (wraps)
// -----------------------------------------------------------------------------
module axis_s_bk_bridge #(
  parameter int DATA_W     = 32,
  parameter int USER_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          axis_tvalid,
  input  logic [DATA_W-1:0]             axis_tdata,
  input  logic [DATA_W/8-1:0]           axis_tstrb,
  input  logic [DATA_W/8-1:0]           axis_tkeep,
  input  logic                          axis_tlast,
  input  logic [USER_W-1:0]             axis_tuser,
  output logic                          axis_tready,
  output logic                          bk_start,
  output logic [DATA_W-1:0]             bk_data,
  output logic [DATA_W/8-1:0]           bk_tstrb,
  output logic [DATA_W/8-1:0]           bk_tkeep,
  output logic [USER_W-1:0]             bk_user,
  output logic                          bk_last,
  input  logic                          bk_nordy,
  input  logic                          bk_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   done_cnt
);

  localparam int SW = DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2 * SW + USER_W + 1;
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [15:0]     r_done_cnt;
  logic            w_push;
  logic            w_pop;
  logic            w_done_acc;

  // Held low while reset is asserted even though the level is already zero.
  assign axis_tready = (r_level != LVL_FULL) && !axi_areset;
  assign w_push      = axis_tvalid && axis_tready;
  assign fifo_level  = r_level;
  assign done_cnt    = r_done_cnt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs. bk_nordy matters only when leaving IDLE;
  // bk_done matters only while a transaction is outstanding.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_done_acc   = 1'b0;
    bk_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_level != '0) && !bk_nordy) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        bk_start = 1'b1;
        if (bk_done) begin
          w_done_acc   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bk_done) begin
          w_done_acc   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: plain array with no reset so it can map onto RAM.
  // tready is low during reset, so nothing is written then.
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers double as the registered RAM read. They load only on
  // the IDLE->START pop, so the payload stays stable through bk_done and
  // afterwards until the next pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      bk_data  <= '0;
      bk_tstrb <= '0;
      bk_tkeep <= '0;
      bk_user  <= '0;
      bk_last  <= 1'b0;
    end else if (w_pop) begin
      {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last} <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_done_cnt <= '0;
    end else if (w_done_acc) begin
      r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_s_bk_bridge.sv
module tb_axis_s_bk_bridge;

  localparam int DW    = 32;
  localparam int UW    = 2;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            axis_tvalid;
  logic [DW-1:0]   axis_tdata;
  logic [SW-1:0]   axis_tstrb;
  logic [SW-1:0]   axis_tkeep;
  logic            axis_tlast;
  logic [UW-1:0]   axis_tuser;
  logic            axis_tready;
  logic            bk_start;
  logic [DW-1:0]   bk_data;
  logic [SW-1:0]   bk_tstrb;
  logic [SW-1:0]   bk_tkeep;
  logic [UW-1:0]   bk_user;
  logic            bk_last;
  logic            bk_nordy;
  logic            bk_done;
  logic [2:0]      fifo_level;
  logic [15:0]     done_cnt;

  always #5 clk = ~clk;

  axis_s_bk_bridge #(
    .DATA_W    (DW),
    .USER_W    (UW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .axis_tvalid(axis_tvalid),
    .axis_tdata (axis_tdata),
    .axis_tstrb (axis_tstrb),
    .axis_tkeep (axis_tkeep),
    .axis_tlast (axis_tlast),
    .axis_tuser (axis_tuser),
    .axis_tready(axis_tready),
    .bk_start   (bk_start),
    .bk_data    (bk_data),
    .bk_tstrb   (bk_tstrb),
    .bk_tkeep   (bk_tkeep),
    .bk_user    (bk_user),
    .bk_last    (bk_last),
    .bk_nordy   (bk_nordy),
    .bk_done    (bk_done),
    .fifo_level (fifo_level),
    .done_cnt   (done_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [SW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          tlast;
    logic          nordy;
    logic          done;
    logic          exp_tready;
    logic          exp_start;
    logic [2:0]    exp_level;
    logic [15:0]   exp_cnt;
    logic [DW-1:0] exp_data;
    logic [UW-1:0] exp_user;
    logic          exp_last;
  } vec_t;

  // Reference model: FIFO contents as a queue, plus whether a backend
  // transaction is outstanding and whether it was issued this cycle.
  beat_t       m_q[$];
  bit          m_busy;
  bit          m_fresh;
  beat_t       m_pay;
  int unsigned m_cnt;
  bit          last_acc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = $urandom;
    b.strb = SW'($urandom_range(0, 15));
    b.keep = SW'($urandom_range(0, 15));
    b.user = UW'($urandom_range(0, 3));
    b.last = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic beat_t mk_beat(logic [DW-1:0] d, logic [UW-1:0] u, logic l);
    beat_t b;
    b.data = d;
    b.strb = 4'hF;
    b.keep = 4'hF;
    b.user = u;
    b.last = l;
    return b;
  endfunction

  function automatic vec_t mk_vec(logic v, logic [DW-1:0] d, logic [UW-1:0] u, logic l,
                                  logic nordy, logic done, logic e_rdy, logic e_st,
                                  logic [2:0] e_lvl, logic [15:0] e_cnt,
                                  logic [DW-1:0] e_d, logic [UW-1:0] e_u, logic e_l);
    vec_t r;
    r.tvalid = v;  r.tdata = d;  r.tuser = u;  r.tlast = l;
    r.nordy = nordy;  r.done = done;
    r.exp_tready = e_rdy;  r.exp_start = e_st;  r.exp_level = e_lvl;
    r.exp_cnt = e_cnt;  r.exp_data = e_d;  r.exp_user = e_u;  r.exp_last = e_l;
    return r;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_busy  = 0;
    m_fresh = 0;
    m_pay   = '{default: '0};
    m_cnt   = 0;
  endtask

  task automatic drive(bit v, beat_t b, bit nordy, bit done);
    axis_tvalid = v;
    axis_tdata  = b.data;
    axis_tstrb  = b.strb;
    axis_tkeep  = b.keep;
    axis_tuser  = b.user;
    axis_tlast  = b.last;
    bk_nordy    = nordy;
    bk_done     = done;
  endtask

  task automatic check_model();
    chk("tready", 32'(axis_tready), 32'(m_q.size() != DEPTH));
    chk("bk_start", 32'(bk_start), 32'(m_fresh));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("done_cnt", 32'(done_cnt), 32'(m_cnt[15:0]));
    chk("bk_data", bk_data, m_pay.data);
    chk("bk_side", 32'({bk_tstrb, bk_tkeep, bk_user, bk_last}),
        32'({m_pay.strb, m_pay.keep, m_pay.user, m_pay.last}));
  endtask

  // Apply the rules of one clock edge to the model, then step the clock.
  task automatic advance();
    bit    acc;
    bit    pop;
    bit    busy0;
    beat_t b;
    busy0 = m_busy;
    acc   = axis_tvalid && (m_q.size() < DEPTH);
    pop   = !busy0 && (m_q.size() > 0) && !bk_nordy;
    if (busy0 && bk_done) begin
      m_cnt++;
      m_busy = 0;
    end
    if (pop) begin
      m_pay  = m_q.pop_front();
      m_busy = 1;
    end
    m_fresh = pop;
    if (acc) begin
      b.data = axis_tdata;  b.strb = axis_tstrb;  b.keep = axis_tkeep;
      b.user = axis_tuser;  b.last = axis_tlast;
      m_q.push_back(b);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(bit v, beat_t b, bit nordy, bit done);
    drive(v, b, nordy, done);
    #1;
    check_model();
    advance();
  endtask

  task automatic do_reset(int cycles, bit mid_flight);
    beat_t z;
    z = '{default: '0};
    drive(0, z, 0, 0);
    rst = 1'b1;
    if (mid_flight) begin
      #1;
      chk("rst async bk_start", 32'(bk_start), 0);
      chk("rst async level", 32'(fifo_level), 0);
      chk("rst async cnt", 32'(done_cnt), 0);
      chk("rst async data", bk_data, 0);
    end
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst tready", 32'(axis_tready), 0);
    chk("rst bk_start", 32'(bk_start), 0);
    chk("rst level", 32'(fifo_level), 0);
    chk("rst cnt", 32'(done_cnt), 0);
    chk("rst payload", 32'({bk_data[7:0], bk_tstrb, bk_tkeep, bk_user, bk_last}), 0);
    rst = 1'b0;
    model_clear();
  endtask

  vec_t  vecs[10];
  beat_t pend[8];
  logic [DW-1:0] seen[8];
  int    start_at[8];
  int    idx;
  int    starts;

  initial begin
    beat_t z;
    z = '{default: '0};
    rst = 1'b1;
    drive(0, z, 0, 0);
    model_clear();
    do_reset(3, 0);

    // ---------------- Single beat + spurious done (table) ----------------
    //                 v  data          u  l nordy done rdy st lvl cnt  exp_data      eu el
    vecs[0] = mk_vec(1, 32'hA5A5_0001, 2, 1, 0, 0,   1, 0, 0, 0, 32'h0,         0, 0);
    vecs[1] = mk_vec(0, 32'h0,         0, 0, 0, 0,   1, 0, 1, 0, 32'h0,         0, 0);
    vecs[2] = mk_vec(0, 32'h0,         0, 0, 0, 0,   1, 1, 0, 0, 32'hA5A5_0001, 2, 1);
    vecs[3] = mk_vec(0, 32'h0,         0, 0, 0, 0,   1, 0, 0, 0, 32'hA5A5_0001, 2, 1);
    vecs[4] = mk_vec(0, 32'h0,         0, 0, 0, 0,   1, 0, 0, 0, 32'hA5A5_0001, 2, 1);
    vecs[5] = mk_vec(0, 32'h0,         0, 0, 0, 1,   1, 0, 0, 0, 32'hA5A5_0001, 2, 1);
    vecs[6] = mk_vec(0, 32'h0,         0, 0, 0, 0,   1, 0, 0, 1, 32'hA5A5_0001, 2, 1);
    vecs[7] = mk_vec(0, 32'h0,         0, 0, 0, 1,   1, 0, 0, 1, 32'hA5A5_0001, 2, 1);
    vecs[8] = mk_vec(0, 32'h0,         0, 0, 0, 0,   1, 0, 0, 1, 32'hA5A5_0001, 2, 1);
    vecs[9] = mk_vec(0, 32'h0,         0, 0, 0, 0,   1, 0, 0, 1, 32'hA5A5_0001, 2, 1);
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].tvalid, mk_beat(vecs[i].tdata, vecs[i].tuser, vecs[i].tlast),
            vecs[i].nordy, vecs[i].done);
      #1;
      chk($sformatf("vec%0d tready", i), 32'(axis_tready), 32'(vecs[i].exp_tready));
      chk($sformatf("vec%0d bk_start", i), 32'(bk_start), 32'(vecs[i].exp_start));
      chk($sformatf("vec%0d level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d done_cnt", i), 32'(done_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d bk_data", i), bk_data, vecs[i].exp_data);
      chk($sformatf("vec%0d user/last", i), 32'({bk_user, bk_last}),
          32'({vecs[i].exp_user, vecs[i].exp_last}));
      advance();
    end
    chk("single strb/keep", 32'({bk_tstrb, bk_tkeep}), 32'h0000_00FF);
    $display("single beat: bk_data=0x%0h done_cnt=%0d", bk_data, done_cnt);

    // ---------------- Backpressure fill ----------------
    for (int i = 0; i < 5; i++) pend[i] = mk_beat(32'(i + 1), UW'(i), 1'(i == 4));
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1, pend[idx], 1, 0);
      if (last_acc) idx++;
    end
    chk("bp accepted", 32'(idx), 4);
    chk("bp level", 32'(fifo_level), 4);
    chk("bp tready", 32'(axis_tready), 0);
    starts = 0;
    for (int c = 0; c < 40 && starts < 5; c++) begin
      drive(idx < 5, pend[idx < 5 ? idx : 4], 0, 1);
      #1;
      check_model();
      if (bk_start) begin
        seen[starts] = bk_data;
        starts++;
      end
      advance();
      if (last_acc) idx++;
    end
    chk("bp starts", 32'(starts), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("bp order%0d", k), seen[k], 32'(k + 1));
    chk("bp done_cnt", 32'(done_cnt), 6);
    $display("backpressure: %0d starts, done_cnt=%0d", starts, done_cnt);
    cyc(0, z, 0, 0);

    // ---------------- Done in START: 8 beats, one start per 2 cycles ----------------
    for (int i = 0; i < 8; i++) pend[i] = rand_beat();
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(1, pend[idx], 1, 0);
      if (last_acc) idx++;
    end
    starts = 0;
    for (int c = 0; c < 60 && starts < 8; c++) begin
      drive(idx < 8, pend[idx < 8 ? idx : 7], 0, 1);
      #1;
      check_model();
      if (bk_start) begin
        seen[starts]     = bk_data;
        start_at[starts] = c;
        starts++;
      end
      advance();
      if (last_acc) idx++;
    end
    chk("dis starts", 32'(starts), 8);
    for (int k = 1; k < 8; k++)
      chk($sformatf("dis spacing%0d", k), 32'(start_at[k] - start_at[k-1]), 2);
    for (int k = 0; k < 8; k++) chk($sformatf("dis order%0d", k), seen[k], pend[k].data);
    $display("done-in-start: %0d starts, done_cnt=%0d", starts, done_cnt);

    // ---------------- Spurious done in IDLE, FIFO empty ----------------
    cyc(0, z, 0, 0);
    cyc(0, z, 0, 1);
    cyc(0, z, 0, 1);
    cyc(0, z, 0, 0);
    chk("spurious cnt", 32'(done_cnt), 14);
    $display("spurious done: done_cnt=%0d", done_cnt);

    // ---------------- Reset mid-flight ----------------
    for (int c = 0; c < 4; c++) cyc(1, rand_beat(), 1, 0);
    cyc(0, z, 0, 0);
    cyc(0, z, 0, 0);
    cyc(0, z, 0, 0);
    chk("mid level", 32'(fifo_level), 3);
    chk("mid in wait", 32'(bk_start), 0);
    do_reset(2, 1);
    for (int c = 0; c < 6; c++) cyc(0, z, 0, 0);
    $display("reset mid-flight: level=%0d done_cnt=%0d", fifo_level, done_cnt);

    // ---------------- Simultaneous push/pop around level 2 ----------------
    cyc(1, rand_beat(), 1, 0);
    cyc(1, rand_beat(), 1, 0);
    for (int c = 0; c < 20; c++) cyc(1'($urandom_range(0, 1)), rand_beat(), 0, 1'($urandom_range(0, 1)));
    $display("push/pop: level=%0d done_cnt=%0d", fifo_level, done_cnt);

    // ---------------- Random soak, then drain ----------------
    for (int c = 0; c < 400; c++)
      cyc(1'($urandom_range(0, 1)), rand_beat(), $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 4);
    for (int c = 0; c < 20; c++) cyc(0, z, 0, 1);
    chk("drain level", 32'(fifo_level), 0);
    $display("random soak: done_cnt=%0d", done_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
